// File: rtl/imem_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_sram_ctrl_if
//   Groups every bus signal of the instruction-memory SRAM controller:
//   the fetch port, the single-word store port and the external SRAM pins.
//
//   Modports
//     slave  : the controller (imem_sram_ctrl)
//     master : its environment (fetch stage + MEM stage + SRAM device)
//
//   Handshake rules
//     Fetch : im_addr may change at any time. im_data belongs to the current
//             im_addr in every cycle where im_stall is 0.
//     Store : st_req rises with st_addr/st_data/st_be stable and all four
//             stay stable until the cycle in which st_ack is 1. st_ack is a
//             one-cycle pulse. The requester drops st_req on the clock edge
//             that ends the st_ack cycle.
// ---------------------------------------------------------------------------
interface imem_sram_ctrl_if;
  // fetch port
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        im_stall;
  // store port
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ack;
  // external asynchronous SRAM
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o;
  logic [31:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  modport slave (
    input  im_addr, st_req, st_addr, st_data, st_be, sram_dq_i,
    output im_data, im_stall, st_ack,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n,
    output sram_we_n, sram_be_n
  );

  modport master (
    output im_addr, st_req, st_addr, st_data, st_be, sram_dq_i,
    input  im_data, im_stall, st_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n,
    input  sram_we_n, sram_be_n
  );
endinterface

// File: rtl/imem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// imem_sram_ctrl
//   Instruction-side responder for the fetch stage. Reads instruction words
//   from the external 32-bit asynchronous SRAM (4 MiB window at BASE_ADDR),
//   keeps the last word in a one-entry fetch buffer, and stalls the fetch
//   stage (im_stall) until the word for the current im_addr is available.
//   Single-word stores from the MEM stage share the SRAM and win over fetch
//   misses. A store that hits the buffered word invalidates it so that
//   self-modifying code refetches.
//
//   Ports
//     clk      : clock
//     rst      : asynchronous active-low reset
//     bus      : imem_sram_ctrl_if.slave (fetch, store and SRAM pins)
//     state_o  : current FSM state (debug), encoding of state_t below
//
//   Parameters
//     WAIT_CYCLES : extra SRAM access cycles beyond the minimum (0..7)
//     BASE_ADDR   : start of the SRAM window, bits [31:22] compared
//     NOP_WORD    : word returned for fetches outside the window
// ---------------------------------------------------------------------------
module imem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  imem_sram_ctrl_if.slave   bus,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;          // remaining access cycles in READ / WR_PULSE
  logic        tag_valid_q, tag_valid_d;
  logic [29:0] tag_q, tag_d;          // word address of the buffered instruction
  logic [31:0] data_q, data_d;        // buffered instruction word
  logic [29:0] rd_tag_q, rd_tag_d;    // word address latched when a READ starts
  logic [19:0] addr_q, addr_d;        // SRAM word address held for the access
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wbe_q, wbe_d;
  logic        skip_ack_q, skip_ack_d; // ack for a store that needs no SRAM cycle

  logic in_win;
  logic st_in_win;
  logic hit;
  logic st_hits_tag;

  assign in_win      = (bus.im_addr[31:22] == BASE_ADDR[31:22]);
  assign st_in_win   = (bus.st_addr[31:22] == BASE_ADDR[31:22]);
  assign hit         = tag_valid_q && (tag_q == bus.im_addr[31:2]);
  assign st_hits_tag = tag_valid_q && (tag_q == bus.st_addr[31:2]);

  // Byte-offset bits carry no meaning for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.im_addr[1:0], bus.st_addr[1:0]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      tag_valid_q <= 1'b0;
      tag_q       <= 30'd0;
      data_q      <= NOP_WORD;
      rd_tag_q    <= 30'd0;
      addr_q      <= 20'd0;
      wdata_q     <= 32'd0;
      wbe_q       <= 4'd0;
      skip_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      rd_tag_q    <= rd_tag_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wbe_q       <= wbe_d;
      skip_ack_q  <= skip_ack_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_valid_d = tag_valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    rd_tag_d    = rd_tag_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wbe_d       = wbe_q;
    skip_ack_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // skip_ack_q marks the ack cycle of an out-of-window store; st_req
        // is still high then and must not start a second store.
        if (bus.st_req && !skip_ack_q) begin
          if (st_in_win) begin
            state_d = S_WR_SETUP;
            addr_d  = bus.st_addr[21:2];
            wdata_d = bus.st_data;
            wbe_d   = bus.st_be;
            if (st_hits_tag) begin
              tag_valid_d = 1'b0;
            end
          end else begin
            skip_ack_d = 1'b1;
          end
        end else if (in_win && !hit) begin
          state_d  = S_READ;
          cnt_d    = WAIT_LOAD;
          addr_d   = bus.im_addr[21:2];
          rd_tag_d = bus.im_addr[31:2];
        end
      end

      S_READ: begin
        // Result is captured for the address latched at entry even if
        // im_addr moved meanwhile; IDLE then misses and reads again.
        if (cnt_q == 3'd0) begin
          state_d     = S_IDLE;
          data_d      = bus.sram_dq_i;
          tag_d       = rd_tag_q;
          tag_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WAIT_LOAD;
      end

      S_WR_PULSE: begin
        if (cnt_q == 3'd0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_WR_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from the registered state only, so reset releases the
  // SRAM controls immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.sram_ce_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_be_n  = 4'hF;
    bus.sram_dq_oe = 1'b0;
    bus.st_ack     = skip_ack_q;

    case (state_q)
      S_READ: begin
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        bus.sram_be_n = 4'h0;
      end
      S_WR_SETUP: begin
        bus.sram_ce_n  = 1'b0;
        bus.sram_be_n  = ~wbe_q;
        bus.sram_dq_oe = 1'b1;
      end
      S_WR_PULSE: begin
        bus.sram_ce_n  = 1'b0;
        bus.sram_we_n  = 1'b0;
        bus.sram_be_n  = ~wbe_q;
        bus.sram_dq_oe = 1'b1;
      end
      S_WR_HOLD: begin
        // we_n rises first while address and data stay on the bus.
        bus.sram_ce_n  = 1'b0;
        bus.sram_be_n  = ~wbe_q;
        bus.sram_dq_oe = 1'b1;
        bus.st_ack     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.sram_addr = addr_q;
  assign bus.sram_dq_o = wdata_q;
  assign bus.im_stall  = in_win && !(hit && (state_q == S_IDLE));
  assign bus.im_data   = in_win ? data_q : NOP_WORD;
  assign state_o       = state_q;

endmodule

// File: tb/tb_imem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_sram_ctrl
//   Self-checking bench for imem_sram_ctrl. Drives fetches and stores,
//   models the SRAM device, and checks responses through a scoreboard whose
//   expectations come from a word-level reference model of the memory and
//   the one-entry fetch buffer.
// ---------------------------------------------------------------------------
module tb_imem_sram_ctrl;
  localparam int          W    = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dut_state;

  always #5 clk = ~clk;

  imem_sram_ctrl_if bus();

  imem_sram_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .state_o(dut_state)
  );

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now(input string why);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s (t=%0t)", why, $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // ---------------- SRAM device ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h3C01_1234 : ((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3);
  endfunction

  logic [31:0] sram_mem [0:63];
  logic        mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!bus.sram_be_n[b])
          sram_mem[bus.sram_addr[5:0]][8*b +: 8] <= bus.sram_dq_o[8*b +: 8];
    end
  end

  assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ?
                         sram_mem[bus.sram_addr[5:0]] : 32'hA5A5_5A5A;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];
  logic        m_valid;
  logic [29:0] m_tag;

  function automatic bit in_window(input logic [31:0] a);
    return a[31:22] == BASE[31:22];
  endfunction

  // Buffer rule: it ends up holding the last in-window address presented.
  function automatic int model_fetch(input logic [31:0] a);
    if (!in_window(a)) return 0;
    if (m_valid && m_tag == a[31:2]) return 0;
    m_valid = 1'b1;
    m_tag   = a[31:2];
    return W + 2;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return in_window(a) ? ref_mem[a[7:2]] : 32'h0000_0000;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (in_window(a)) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      // A held in-window im_addr is refetched at once; otherwise the entry is lost.
      if (m_valid && m_tag == a[31:2] && !in_window(bus.im_addr)) m_valid = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_stall_q[$];
  int          f_issued = 0;
  int          f_done   = 0;
  int          f_cnt    = 0;

  int          s_lat_q[$];
  int          s_we_q[$];
  int          s_issued = 0;
  int          s_done   = 0;
  int          s_abort  = 0;
  int          s_cnt    = 0;
  int          we_cnt   = 0;
  logic [3:0]  cur_be   = 4'h0;

  always @(negedge clk) begin
    check("we_oe_exclusive", {31'b0, (!bus.sram_we_n && !bus.sram_oe_n)}, 32'd0);
    if (bus.sram_dq_oe) check("dq_oe_with_oe_n", {31'b0, bus.sram_oe_n}, 32'd1);
    if (!bus.sram_we_n) check("we_with_dq_oe", {31'b0, bus.sram_dq_oe}, 32'd1);

    if (f_issued != f_done) begin
      if (!bus.im_stall) begin
        if (exp_q.size() == 0 || exp_stall_q.size() == 0) begin
          check("fetch_queue_nonempty", 32'd0, 32'd1);
        end else begin
          check("im_data", bus.im_data, exp_q.pop_front());
          check("im_stall_cycles", 32'(f_cnt), 32'(exp_stall_q.pop_front()));
        end
        f_done++;
        f_cnt = 0;
      end else begin
        f_cnt++;
      end
    end

    if (s_issued != s_done + s_abort) begin
      check("store_oe_n", {31'b0, bus.sram_oe_n}, 32'd1);
      if (!bus.sram_we_n) begin
        we_cnt++;
        check("store_be_n", {28'b0, bus.sram_be_n}, {28'b0, ~cur_be});
      end
      if (bus.st_ack) begin
        check("st_ack_latency", 32'(s_cnt), 32'(s_lat_q.pop_front()));
        check("we_low_cycles", 32'(we_cnt), 32'(s_we_q.pop_front()));
        s_done++;
        s_cnt  = 0;
        we_cnt = 0;
      end else begin
        s_cnt++;
      end
    end else begin
      check("st_ack_idle", {31'b0, bus.st_ack}, 32'd0);
      s_cnt  = 0;
      we_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // exp_override < 0: stall length comes from the model.
  task automatic start_fetch(input logic [31:0] a, input int exp_override, output int st);
    st = model_fetch(a);
    if (exp_override >= 0) st = exp_override;
    exp_q.push_back(model_word(a));
    exp_stall_q.push_back(st);
    bus.im_addr = a;
    f_issued++;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (f_issued != f_done && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (f_issued != f_done) finish_now("fetch");
  endtask

  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.st_addr = a;
    bus.st_data = d;
    bus.st_be   = be;
    bus.st_req  = 1'b1;
    cur_be      = be;
    s_lat_q.push_back(in_window(a) ? W + 3 : 1);
    s_we_q.push_back(in_window(a) ? W + 1 : 0);
    s_issued++;
  endtask

  task automatic wait_store();
    int n = 0;
    while (s_issued != s_done + s_abort && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (s_issued != s_done + s_abort) finish_now("store");
    #1;
    bus.st_req = 1'b0;
    model_store(bus.st_addr, bus.st_data, bus.st_be);
  endtask

  logic [31:0] oow_addr [0:3];

  initial begin
    #500000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          st;
    logic [31:0] a;
    logic [31:0] b_addr;
    int          n;

    oow_addr[0] = 32'h7FFF_FFFC;
    oow_addr[1] = 32'h0000_1000;
    oow_addr[2] = 32'hBFC0_0000;
    oow_addr[3] = 32'h8040_0000;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_valid     = 1'b0;
    m_tag       = 30'd0;
    bus.im_addr = 32'h7FFF_FFFC;
    bus.st_req  = 1'b0;
    bus.st_addr = 32'd0;
    bus.st_data = 32'd0;
    bus.st_be   = 4'd0;

    // 1: reset state, fetch-stage reset address outside the window
    repeat (3) begin
      @(negedge clk);
      check("rst_im_data", bus.im_data, 32'd0);
      check("rst_im_stall", {31'b0, bus.im_stall}, 32'd0);
      check("rst_ce_n", {31'b0, bus.sram_ce_n}, 32'd1);
      check("rst_we_n", {31'b0, bus.sram_we_n}, 32'd1);
      check("rst_be_n", {28'b0, bus.sram_be_n}, 32'hF);
      check("rst_dq_oe", {31'b0, bus.sram_dq_oe}, 32'd0);
      check("rst_sram_addr", {12'b0, bus.sram_addr}, 32'd0);
      check("rst_sram_dq_o", bus.sram_dq_o, 32'd0);
    end
    sync();
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("oow_im_data", bus.im_data, 32'd0);
      check("oow_im_stall", {31'b0, bus.im_stall}, 32'd0);
      check("oow_ce_n", {31'b0, bus.sram_ce_n}, 32'd1);
    end

    // 2: first in-window fetch
    sync();
    start_fetch(32'h8000_0000, -1, st);
    @(negedge clk);
    @(negedge clk);
    check("read_sram_addr", {12'b0, bus.sram_addr}, 32'd0);
    check("read_oe_n", {31'b0, bus.sram_oe_n}, 32'd0);
    check("read_ce_n", {31'b0, bus.sram_ce_n}, 32'd0);
    wait_fetch();

    // 3: sequential fetches, then hold the last address
    for (int i = 0; i < 4; i++) begin
      sync();
      start_fetch(BASE + 32'(i * 4), -1, st);
      if (st != 0) begin
        @(negedge clk);
        @(negedge clk);
        check("seq_sram_addr", {12'b0, bus.sram_addr}, 32'(i));
      end
      wait_fetch();
    end
    sync();
    start_fetch(32'h8000_000C, -1, st);
    repeat (4) begin
      @(negedge clk);
      check("held_no_reread_ce_n", {31'b0, bus.sram_ce_n}, 32'd1);
    end
    wait_fetch();

    // 4: partial store, then read it back
    sync();
    start_store(32'h8000_0010, 32'hDEAD_BEEF, 4'b0011);
    wait_store();
    repeat (4) @(posedge clk);
    sync();
    start_fetch(32'h8000_0010, -1, st);
    wait_fetch();

    // 5a: store and fetch miss in the same cycle
    sync();
    start_fetch(32'h8000_0020, -1, st);
    wait_fetch();
    b_addr = 32'h8000_0024;
    sync();
    start_store(32'h8000_0030, 32'h1234_5678, 4'hF);
    start_fetch(b_addr, 2 * W + 6, st);
    wait_store();
    wait_fetch();

    // 5b: store to the buffered word, refetch returns new data
    sync();
    start_store(b_addr, 32'hCAFE_F00D, 4'b1010);
    wait_store();
    start_fetch(b_addr, W + 2, st);
    wait_fetch();

    // 6: reset during the write pulse
    sync();
    start_store(32'h8000_0040, 32'h0BAD_0BAD, 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sram_we_n && n < 10);
    if (bus.sram_we_n) finish_now("we_n low");
    #1;
    rst = 1'b0;
    #1;
    check("abort_we_n", {31'b0, bus.sram_we_n}, 32'd1);
    check("abort_dq_oe", {31'b0, bus.sram_dq_oe}, 32'd0);
    check("abort_ce_n", {31'b0, bus.sram_ce_n}, 32'd1);
    check("abort_st_ack", {31'b0, bus.st_ack}, 32'd0);
    bus.st_req = 1'b0;
    s_abort++;
    void'(s_lat_q.pop_front());
    void'(s_we_q.pop_front());
    repeat (2) @(posedge clk);
    sync();
    rst = 1'b1;
    #1;
    check("post_rst_stall", {31'b0, bus.im_stall}, 32'd1);
    check("post_rst_im_data", bus.im_data, 32'd0);
    m_valid = 1'b0;
    start_fetch(b_addr, -1, st);
    wait_fetch();

    // random mix
    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        if ($urandom_range(0, 7) == 0) a = oow_addr[$urandom_range(0, 3)];
        else a = BASE | {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        sync();
        start_fetch(a, -1, st);
        wait_fetch();
      end else if (r <= 8) begin
        if ($urandom_range(0, 7) == 0) a = oow_addr[$urandom_range(0, 3)];
        else a = BASE | {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        sync();
        start_store(a, $urandom, 4'($urandom_range(0, 15)));
        wait_store();
        repeat (6) @(posedge clk);
      end else begin
        sync();
        start_fetch(bus.im_addr, -1, st);
        wait_fetch();
      end
    end

    repeat (5) @(posedge clk);
    check("fetch_queue_drained", 32'(exp_q.size()), 32'd0);
    check("store_queue_drained", 32'(s_lat_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
